// File: rtl/nonce_result_scanner.sv
// Scans NUM_NONCES hash words from shared memory against a difficulty target and
// writes a 4-word result record (first hit, minimum hash, its index, hit count).
module nonce_result_scanner #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] hash_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int CW = $clog2(NUM_NONCES + 1);
  localparam logic [CW-1:0] N_LAST = CW'(NUM_NONCES);
  localparam logic [CW-1:0] N_PENULT = CW'(NUM_NONCES - 1);

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t        state;
  logic [15:0]   hash_base;
  logic [15:0]   result_base;
  logic [31:0]   target_q;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] cap_idx;
  logic [CW-1:0] hit_cnt;
  logic          found;
  logic [15:0]   first_idx;
  logic [31:0]   min_hash;
  logic [15:0]   min_idx;
  logic          rd_valid1;
  logic          rd_valid2;
  logic [1:0]    wr_k;
  logic [31:0]   rec_word;

  assign mem_clk = clk;

  always_comb begin
    rec_word = 32'h0;
    case (wr_k)
      2'd0: rec_word = {found, 15'b0, (found ? first_idx : 16'hFFFF)};
      2'd1: rec_word = min_hash;
      2'd2: rec_word = {16'b0, min_idx};
      2'd3: rec_word = {16'b0, 16'(hit_cnt)};
      default: rec_word = 32'h0;
    endcase
  end

  // rd_valid1/rd_valid2 follow each issued address through the two-cycle read latency
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      done           <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= 16'h0;
      mem_write_data <= 32'h0;
      hash_base      <= 16'h0;
      result_base    <= 16'h0;
      target_q       <= 32'h0;
      issue_cnt      <= '0;
      cap_idx        <= '0;
      hit_cnt        <= '0;
      found          <= 1'b0;
      first_idx      <= 16'h0;
      min_hash       <= 32'h0;
      min_idx        <= 16'h0;
      rd_valid1      <= 1'b0;
      rd_valid2      <= 1'b0;
      wr_k           <= 2'd0;
    end else begin
      rd_valid2 <= rd_valid1;
      if (rd_valid2) begin
        if (mem_read_data < target_q) begin
          hit_cnt <= hit_cnt + 1'b1;
          if (!found) begin
            found     <= 1'b1;
            first_idx <= 16'(cap_idx);
          end
        end
        if (mem_read_data < min_hash) begin
          min_hash <= mem_read_data;
          min_idx  <= 16'(cap_idx);
        end
        cap_idx <= cap_idx + 1'b1;
      end

      case (state)
        IDLE: begin
          rd_valid1 <= 1'b0;
          if (start) begin
            hash_base   <= hash_addr;
            result_base <= result_addr;
            target_q    <= target;
            done        <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= hash_addr;
            issue_cnt   <= CW'(1);
            cap_idx     <= '0;
            hit_cnt     <= '0;
            found       <= 1'b0;
            min_hash    <= 32'hFFFF_FFFF;
            min_idx     <= 16'h0;
            wr_k        <= 2'd0;
            rd_valid1   <= 1'b1;
            state       <= READ;
          end
        end
        READ: begin
          if (issue_cnt < N_LAST) begin
            mem_addr  <= hash_base + 16'(issue_cnt);
            issue_cnt <= issue_cnt + 1'b1;
            rd_valid1 <= 1'b1;
          end else begin
            rd_valid1 <= 1'b0;
          end
          if (issue_cnt >= N_PENULT) state <= DRAIN;
        end
        DRAIN: begin
          rd_valid1 <= 1'b0;
          // The first record word goes out on the same edge the last capture is seen complete
          if (cap_idx == N_LAST) begin
            mem_we         <= 1'b1;
            mem_addr       <= result_base;
            mem_write_data <= rec_word;
            wr_k           <= 2'd1;
            state          <= WRITE;
          end
        end
        WRITE: begin
          mem_addr       <= result_base + 16'(wr_k);
          mem_write_data <= rec_word;
          wr_k           <= wr_k + 2'd1;
          if (wr_k == 2'd3) state <= DONE;
        end
        DONE: begin
          mem_we <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Self-checking bench for nonce_result_scanner: fixed vectors, reset abort, held start,
// address wrap and randomized scans against a plain behavioural model.
module tb_nonce_result_scanner;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] hash_addr = 16'h0;
  logic [15:0] result_addr = 16'h0;
  logic [31:0] target = 32'h0;
  logic        done;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = 32'h0;

  logic [31:0] mem [0:65535];
  logic [31:0] words [N];
  int          edge_count = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          e0 = 0;
  int          cycles = 0;

  typedef struct {
    int          edge_n;
    logic [15:0] addr;
  } wr_t;
  wr_t wr_q[$];

  typedef struct {
    logic [15:0]       ha;
    logic [15:0]       ra;
    logic [31:0]       tgt;
    int                pattern;
    bit                hold;
    logic [3:0][31:0]  exp;
  } vec_t;
  vec_t vecs[6];

  nonce_result_scanner #(.NUM_NONCES(N)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .hash_addr(hash_addr),
    .result_addr(result_addr),
    .target(target),
    .done(done),
    .mem_clk(mem_clk),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_count <= edge_count + 1;

  // Registered-read memory: address seen at edge N+1, data sampled by the DUT at N+2
  always @(posedge clk) begin
    mem_read_data <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_write_data;
  end

  always @(negedge clk) if (mem_we) wr_q.push_back('{edge_count, mem_addr});

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fillPattern(input int p);
    for (int i = 0; i < N; i++) begin
      case (p)
        0: words[i] = 32'h10 * (i + 1);
        1: words[i] = 32'hF000_0000 - i;
        2: words[i] = 32'h1234_5678;
        default: words[i] = 32'hFFFF_FFFF;
      endcase
    end
  endtask

  function automatic logic [3:0][31:0] refModel(input logic [31:0] tgt);
    logic [3:0][31:0] r;
    int hits = 0;
    int first = -1;
    int mi = -1;
    logic [31:0] mn = 32'hFFFF_FFFF;
    for (int i = 0; i < N; i++) begin
      if (words[i] < tgt) begin
        hits++;
        if (first < 0) first = i;
      end
      if (words[i] < mn) mn = words[i];
    end
    for (int i = 0; i < N; i++) if (mi < 0 && words[i] == mn) mi = i;
    if (mi < 0) mi = 0;
    r[0] = (first < 0) ? 32'h0000_FFFF : {1'b1, 15'b0, 16'(first)};
    r[1] = mn;
    r[2] = 32'(mi);
    r[3] = 32'(hits);
    return r;
  endfunction

  task automatic loadMemory(input logic [15:0] ha, input logic [15:0] ra);
    for (int i = 0; i < N; i++) mem[16'(ha + 16'(i))] = words[i];
    for (int k = 0; k < 4; k++) mem[16'(ra + 16'(k))] = 32'hDEAD_BEEF;
    wr_q.delete();
  endtask

  task automatic applyStimulus(input logic [15:0] ha, input logic [15:0] ra,
                               input logic [31:0] tgt, input bit hold);
    loadMemory(ha, ra);
    @(negedge clk);
    hash_addr = ha;
    result_addr = ra;
    target = tgt;
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = edge_count;
    if (!hold) start = 1'b0;
    hash_addr = ~ha;
    result_addr = ~ra;
    target = ~tgt;
    cycles = -1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = edge_count - e0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic checkScan(input string name, input logic [15:0] ha, input logic [15:0] ra,
                           input logic [31:0] tgt, input bit hold, input logic [3:0][31:0] exp);
    applyStimulus(ha, ra, tgt, hold);
    checkOutput({name, " done_latency"}, 32'(cycles), 32'(N + 6));
    checkOutput({name, " write_count"}, 32'(wr_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < wr_q.size()) begin
        checkOutput($sformatf("%s wr%0d_edge", name, k), 32'(wr_q[k].edge_n - e0), 32'(N + 2 + k));
        checkOutput($sformatf("%s wr%0d_addr", name, k), 32'(wr_q[k].addr), 32'(16'(ra + 16'(k))));
      end
      checkOutput($sformatf("%s rec%0d", name, k), mem[16'(ra + 16'(k))], exp[k]);
    end
    if (hold) begin
      repeat (5) @(posedge clk);
      #1;
      checkOutput({name, " no_rescan_writes"}, 32'(wr_q.size()), 32'd4);
      checkOutput({name, " done_held"}, 32'(done), 32'd1);
    end
  endtask

  initial begin
    logic [3:0][31:0] e;
    logic [31:0] mask;
    logic [15:0] ha;
    for (int a = 0; a < 65536; a++) mem[a] = 32'h0;

    #1;
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset mem_we", 32'(mem_we), 32'd0);
    checkOutput("reset mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset wdata", mem_write_data, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("mem_clk follows clk", 32'(mem_clk), 32'(clk));

    vecs[0] = '{16'h0100, 16'h0800, 32'h35, 0, 1'b0, {32'h3, 32'h0, 32'h10, 32'h8000_0000}};
    vecs[1] = '{16'h0200, 16'h0900, 32'h0, 1, 1'b0, {32'h0, 32'hF, 32'hEFFF_FFF1, 32'h0000_FFFF}};
    vecs[2] = '{16'h0300, 16'h0A00, 32'h1234_5679, 2, 1'b0, {32'h10, 32'h0, 32'h1234_5678, 32'h8000_0000}};
    vecs[3] = '{16'hFFF8, 16'hFFFE, 32'h35, 0, 1'b0, {32'h3, 32'h0, 32'h10, 32'h8000_0000}};
    vecs[4] = '{16'h0400, 16'h0B00, 32'h0, 3, 1'b0, {32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_FFFF}};
    vecs[5] = '{16'h0500, 16'h0C00, 32'h35, 0, 1'b1, {32'h3, 32'h0, 32'h10, 32'h8000_0000}};

    for (int v = 0; v < 6; v++) begin
      fillPattern(vecs[v].pattern);
      checkScan($sformatf("vec%0d", v), vecs[v].ha, vecs[v].ra, vecs[v].tgt, vecs[v].hold, vecs[v].exp);
    end

    // Abort five cycles into READ: nothing may reach the result record
    fillPattern(0);
    loadMemory(16'h0600, 16'h0D00);
    @(negedge clk);
    hash_addr = 16'h0600;
    result_addr = 16'h0D00;
    target = 32'h35;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort mem_we", 32'(mem_we), 32'd0);
    checkOutput("abort mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("abort wdata", mem_write_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("abort write_count", 32'(wr_q.size()), 32'd0);
    checkOutput("abort done_after", 32'(done), 32'd0);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("abort rec%0d_untouched", k), mem[16'(16'h0D00 + 16'(k))], 32'hDEAD_BEEF);
    checkScan("after_abort", 16'h0600, 16'h0D00, 32'h35, 1'b0,
              {32'h3, 32'h0, 32'h10, 32'h8000_0000});

    // Randomized scans; narrow masks force duplicate words and exercise the tie rule
    for (int r = 0; r < 8; r++) begin
      case (r % 4)
        0: mask = 32'hFFFF_FFFF;
        1: mask = 32'h0000_000F;
        2: mask = 32'hF000_0003;
        default: mask = 32'h0000_00FF;
      endcase
      for (int i = 0; i < N; i++) begin
        words[i] = $urandom & mask;
        if ($urandom_range(0, 7) == 0) words[i] = 32'hFFFF_FFFF;
      end
      ha = 16'($urandom);
      target = $urandom & mask;
      e = refModel(target);
      checkScan($sformatf("rand%0d", r), ha, 16'(ha + 16'd200), target, 1'b0, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
